// File: rtl/sequential_multiplier.sv
// Unsigned shift-and-add multiplier: one WIDTH x WIDTH product over WIDTH cycles.
// A start rising edge in IDLE launches an operation; result/done hold until the next one.
module sequential_multiplier #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A_in,
    input  logic [WIDTH-1:0]     B_in,
    output logic [2*WIDTH-1:0]   result,
    output logic                 done
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t          state;
    state_t          state_next;
    logic            start_q;
    logic [PW-1:0]   mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]   acc;
    logic [CW-1:0]   cnt;

    logic            accept_c;
    logic            last_c;
    logic [PW-1:0]   acc_sum_c;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_c) state_next = BUSY;
            BUSY:    if (last_c)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control decode and single shared adder
    always_comb begin
        accept_c  = 1'b0;
        last_c    = 1'b0;
        acc_sum_c = acc + (mplier[0] ? mcand : '0);
        case (state)
            IDLE:    accept_c = start & ~start_q;
            BUSY:    last_c   = (cnt == CW'(WIDTH - 1));
            default: ;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_q <= 1'b0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            result  <= '0;
            done    <= 1'b0;
        end else begin
            start_q <= start;
            if (accept_c) begin
                mcand  <= PW'(A_in);
                mplier <= B_in;
                acc    <= '0;
                cnt    <= '0;
                done   <= 1'b0;
            end else if (state == BUSY) begin
                acc    <= acc_sum_c;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CW'(1);
                if (last_c) begin
                    result <= acc_sum_c;
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sequential_multiplier.sv
// Directed self-checking bench for sequential_multiplier (WIDTH = 4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sequential_multiplier;

    localparam int unsigned WIDTH = 4;

    logic               clk;
    logic               rst;
    logic               start;
    logic [WIDTH-1:0]   A_in;
    logic [WIDTH-1:0]   B_in;
    logic [2*WIDTH-1:0] result;
    logic               done;

    int checks = 0;
    int errors = 0;

    sequential_multiplier #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .A_in   (A_in),
        .B_in   (B_in),
        .result (result),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One-cycle start pulse; checks done low / result held in BUSY, then the product.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int unsigned exp, input int unsigned prev);
        start = 1'b1; A_in = a; B_in = b;
        @(negedge clk);
        start = 1'b0; A_in = ~a; B_in = ~b;
        check({tag, "_accept_done"}, 32'(done), 32'd0);
        check({tag, "_accept_result"}, 32'(result), prev);
        repeat (WIDTH - 1) @(negedge clk);
        check({tag, "_busy_done"}, 32'(done), 32'd0);
        check({tag, "_busy_result"}, 32'(result), prev);
        @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_result"}, 32'(result), exp);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; A_in = '0; B_in = '0;
        repeat (2) @(negedge clk);
        check("reset_result", 32'(result), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Basic and corner products, chained so each run's prior result is known
        run_op("p3x2",   4'd3,  4'd2,  6,   0);
        run_op("p5x5",   4'd5,  4'd5,  25,  6);
        run_op("p15x0",  4'd15, 4'd0,  0,   25);
        run_op("p15x15", 4'd15, 4'd15, 225, 0);
        run_op("p0x15",  4'd0,  4'd15, 0,   225);
        run_op("p10x5",  4'd10, 4'd5,  50,  0);
        repeat (3) @(negedge clk);
        check("hold_done", 32'(done), 32'd1);
        check("hold_result", 32'(result), 32'd50);

        // Reset in the middle of an operation
        start = 1'b1; A_in = 4'd15; B_in = 4'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        check("postrst_done", 32'(done), 32'd0);
        check("postrst_result", 32'(result), 32'd0);

        // Back-to-back operations
        run_op("b2x2", 4'd2, 4'd2, 4, 0);
        @(negedge clk);
        run_op("b3x3", 4'd3, 4'd3, 9, 4);

        // Start held high must not retrigger
        start = 1'b1; A_in = 4'd2; B_in = 4'd4;
        @(negedge clk);
        check("stuck_accept_done", 32'(done), 32'd0);
        repeat (WIDTH) @(negedge clk);
        check("stuck_done", 32'(done), 32'd1);
        check("stuck_result", 32'(result), 32'd8);
        A_in = 4'd9; B_in = 4'd9;
        repeat (6) @(negedge clk);
        check("stuck_hold_done", 32'(done), 32'd1);
        check("stuck_hold_result", 32'(result), 32'd8);
        start = 1'b0;
        @(negedge clk);
        run_op("p7x3", 4'd7, 4'd3, 21, 8);

        // Second start pulse during BUSY is ignored and not queued
        @(negedge clk);
        start = 1'b1; A_in = 4'd6; B_in = 4'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; A_in = 4'd15; B_in = 4'd15;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("ign_busy_done", 32'(done), 32'd0);
        check("ign_busy_result", 32'(result), 32'd21);
        @(negedge clk);
        check("ign_done", 32'(done), 32'd1);
        check("ign_result", 32'(result), 32'd18);
        repeat (6) @(negedge clk);
        check("ign_hold_done", 32'(done), 32'd1);
        check("ign_hold_result", 32'(result), 32'd18);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
